// File: rtl/johnson_phase_monitor.sv
// johnson_phase_monitor: decodes a Johnson counter bus into a registered phase,
// checks step order, counts rotations and holds sticky error flags.
//
// Ports:
//   CLK          rising-edge clock, shared with the Johnson counter
//   Reset        synchronous active-high reset
//   en           sample enable; when low, state and outputs hold
//   q_in         Johnson code from the counter
//   err_clr      clears the sticky flags; a same-cycle new error wins
//   phase        registered one-hot phase
//   phase_idx    registered binary phase index
//   phase_valid  phase/phase_idx hold a decoded legal code
//   cycle_count  completed rotations, wraps
//   illegal_code sticky: a non-Johnson code was sampled
//   seq_error    sticky: a legal code arrived out of order
module johnson_phase_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          en,
  input  logic [WIDTH-1:0]              q_in,
  input  logic                          err_clr,
  output logic [2*WIDTH-1:0]            phase,
  output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
  output logic                          phase_valid,
  output logic [CNT_W-1:0]              cycle_count,
  output logic                          illegal_code,
  output logic                          seq_error
);

  localparam int NP = 2 * WIDTH;
  localparam int IW = $clog2(NP);

  typedef enum logic {
    SYNC,
    TRACK
  } state_t;

  state_t state, state_n;

  // Phase k <= N fills the low k bits; phase k > N keeps the top 2N-k bits.
  function automatic logic [WIDTH-1:0] code_of(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      c[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
    end
    return c;
  endfunction

  logic          legal;
  logic [IW-1:0] idx;
  logic [IW-1:0] succ;
  logic          last;

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int k = 0; k < NP; k++) begin
      if (q_in == code_of(k)) begin
        legal = 1'b1;
        idx   = IW'(k);
      end
    end
  end

  assign last = (phase_idx == IW'(NP - 1));
  assign succ = last ? '0 : phase_idx + IW'(1);

  logic [IW-1:0]    idx_n;
  logic             valid_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ill_hit;
  logic             seq_hit;
  logic [NP-1:0]    phase_n;
  logic             ill_n;
  logic             seq_n;

  always_comb begin
    state_n = state;
    idx_n   = phase_idx;
    valid_n = phase_valid;
    cnt_n   = cycle_count;
    ill_hit = 1'b0;
    seq_hit = 1'b0;
    if (en) begin
      unique case (state)
        SYNC: begin
          if (legal) begin
            idx_n   = idx;
            valid_n = 1'b1;
            state_n = TRACK;
          end else begin
            ill_hit = 1'b1;
            idx_n   = '0;
            valid_n = 1'b0;
          end
        end
        TRACK: begin
          if (!legal) begin
            ill_hit = 1'b1;
            idx_n   = '0;
            valid_n = 1'b0;
            state_n = SYNC;
          end else if (idx == phase_idx) begin
            idx_n = phase_idx;
          end else if (idx == succ) begin
            idx_n = idx;
            if (last) cnt_n = cycle_count + CNT_W'(1);
          end else begin
            seq_hit = 1'b1;
            idx_n   = idx;
          end
        end
        default: state_n = SYNC;
      endcase
    end
    phase_n = valid_n ? ({{(NP-1){1'b0}}, 1'b1} << idx_n) : '0;
    ill_n   = (illegal_code & ~err_clr) | ill_hit;
    seq_n   = (seq_error & ~err_clr) | seq_hit;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state        <= SYNC;
      phase        <= '0;
      phase_idx    <= '0;
      phase_valid  <= 1'b0;
      cycle_count  <= '0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      phase_idx    <= idx_n;
      phase_valid  <= valid_n;
      cycle_count  <= cnt_n;
      illegal_code <= ill_n;
      seq_error    <= seq_n;
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// tb_johnson_phase_monitor: vector table, directed corner sequences and
// random stimulus checked against a lookup-table reference model.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q;
  logic       clr;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       phase_valid;
  logic [7:0] cycle_count;
  logic       illegal_code;
  logic       seq_error;

  johnson_phase_monitor #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK(clk),
    .Reset(rst),
    .en(en),
    .q_in(q),
    .err_clr(clr),
    .phase(phase),
    .phase_idx(phase_idx),
    .phase_valid(phase_valid),
    .cycle_count(cycle_count),
    .illegal_code(illegal_code),
    .seq_error(seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] lc [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                         4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_trk;
  int m_idx;
  bit m_valid;
  int m_cnt;
  bit m_ill;
  bit m_seq;

  function automatic int find(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (lc[i] == c) return i;
    return -1;
  endfunction

  function automatic void model(input logic r, input logic e,
                                input logic c, input logic [3:0] v);
    int k;
    bit ni, ns;
    ni = 0;
    ns = 0;
    if (r) begin
      m_trk = 0; m_idx = 0; m_valid = 0; m_cnt = 0; m_ill = 0; m_seq = 0;
      return;
    end
    if (e) begin
      k = find(v);
      if (k < 0) begin
        ni = 1; m_idx = 0; m_valid = 0; m_trk = 0;
      end else if (!m_trk) begin
        m_idx = k; m_valid = 1; m_trk = 1;
      end else if (k == m_idx) begin
      end else if (k == (m_idx + 1) % 8) begin
        if (m_idx == 7) m_cnt = (m_cnt + 1) % 256;
        m_idx = k;
      end else begin
        ns = 1; m_idx = k;
      end
    end
    m_ill = (m_ill && !c) || ni;
    m_seq = (m_seq && !c) || ns;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic c, input logic [3:0] v);
    int ep;
    rst = r; en = e; clr = c; q = v;
    @(posedge clk);
    model(r, e, c, v);
    #1;
    ep = m_valid ? (1 << m_idx) : 0;
    chk("m_phase", int'(phase), ep);
    chk("m_idx", int'(phase_idx), m_idx);
    chk("m_valid", int'(phase_valid), int'(m_valid));
    chk("m_cnt", int'(cycle_count), m_cnt);
    chk("m_ill", int'(illegal_code), int'(m_ill));
    chk("m_seq", int'(seq_error), int'(m_seq));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] q;
    int         idx;
    logic       valid;
    int         cnt;
    logic       ill;
    logic       seq;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic e, input logic c,
                              input logic [3:0] v, input int i,
                              input logic va, input int n,
                              input logic il, input logic sq);
    vec_t t;
    t.rst = r; t.en = e; t.clr = c; t.q = v; t.idx = i;
    t.valid = va; t.cnt = n; t.ill = il; t.seq = sq;
    vq.push_back(t);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; q = '0;

    // free run, hold, out-of-order, illegal, err_clr cases
    add(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 1, 0, lc[i % 8], i % 8, 1, i / 8, 0, 0);
    add(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 4'b0011, 2, 1, 0, 0, 0);
    add(1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0000, 0, 1, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 1, 1, 0, 0, 0);
    add(0, 1, 0, 4'b0111, 3, 1, 0, 0, 1);
    add(0, 1, 0, 4'b1111, 4, 1, 0, 0, 1);
    add(0, 1, 1, 4'b1111, 4, 1, 0, 0, 0);
    add(0, 1, 1, 4'b1111, 4, 1, 0, 0, 0);
    add(0, 1, 0, 4'b0101, 0, 0, 0, 1, 0);
    add(0, 1, 0, 4'b0011, 2, 1, 0, 1, 0);
    add(0, 1, 1, 4'b0110, 0, 0, 0, 1, 0);
    add(0, 1, 1, 4'b0011, 2, 1, 0, 0, 0);

    foreach (vq[n]) begin
      step(vq[n].rst, vq[n].en, vq[n].clr, vq[n].q);
      chk("v_idx", int'(phase_idx), vq[n].idx);
      chk("v_valid", int'(phase_valid), int'(vq[n].valid));
      chk("v_phase", int'(phase), vq[n].valid ? (1 << vq[n].idx) : 0);
      chk("v_cnt", int'(cycle_count), vq[n].cnt);
      chk("v_ill", int'(illegal_code), int'(vq[n].ill));
      chk("v_seq", int'(seq_error), int'(vq[n].seq));
    end

    // run to three rotations, freeze with en low, then reset mid-rotation
    step(1, 1, 0, 4'b0000);
    for (int i = 0; i <= 24; i++) step(0, 1, 0, lc[i % 8]);
    chk("run_cnt3", int'(cycle_count), 3);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 4'($urandom));
      chk("frz_idx", int'(phase_idx), 0);
      chk("frz_phase", int'(phase), 1);
      chk("frz_valid", int'(phase_valid), 1);
      chk("frz_cnt", int'(cycle_count), 3);
      chk("frz_flags", int'({illegal_code, seq_error}), 0);
    end
    step(0, 1, 0, lc[1]);
    step(0, 1, 0, lc[2]);
    step(1, 1, 1, lc[3]);
    chk("rst_all", int'({phase, phase_idx, phase_valid, cycle_count,
                         illegal_code, seq_error}), 0);
    step(0, 1, 0, lc[5]);
    chk("resync_idx", int'(phase_idx), 5);
    chk("resync_seq", int'(seq_error), 0);
    chk("resync_cnt", int'(cycle_count), 0);

    // rotation counter wrap 255 -> 0
    step(1, 1, 0, 4'b0000);
    for (int i = 0; i <= 2048; i++) begin
      step(0, 1, 0, lc[i % 8]);
      if (i == 2047) chk("wrap_255", int'(cycle_count), 255);
      if (i == 2048) chk("wrap_0", int'(cycle_count), 0);
    end

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 70) v = lc[(m_idx + 1) % 8];
      else if (r < 85) v = lc[m_idx];
      else v = 4'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) == 0, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
